// File: rtl/approx_mult_share_arbiter.sv
// approx_mult_share_arbiter
// Round-robin front end for one shared, purely combinational 8x8 multiplier.
// Only one multiply is in flight at a time. The granted operands are registered
// onto mul_a/mul_b and held for MUL_LAT cycles. The product is then captured and
// returned with the requester id.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A requester may drop req_valid before it is
// granted; that is legal and leaves the round-robin pointer untouched. Once
// rsp_valid is raised, rsp_p/rsp_id stay stable and rsp_valid stays high until
// rsp_ready is sampled high.
module approx_mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_p,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [3:0]        cnt;

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] search_vec;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rr_next;
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  logic               accept;

  assign state_dbg = state;

  // Round-robin search: prefer requests at or above rr_ptr, else wrap to the lowest.
  always_comb begin
    hi_mask     = ~((NUM_REQ'(1) << rr_ptr) - NUM_REQ'(1));
    hi_req      = req_valid & hi_mask;
    search_vec  = (hi_req != '0) ? hi_req : req_valid;
    grant_found = (req_valid != '0);
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (search_vec[i]) begin
        grant_idx = ID_W'(i);
      end
    end
  end

  // Operand mux for the granted requester and the pointer value after it.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[8*i +: 8];
        sel_b = req_b[8*i +: 8];
      end
    end
    rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // One-hot ready, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && (state == ST_IDLE) && grant_found &&
                     (grant_idx == ID_W'(i));
    end
  end

  assign accept = (state == ST_IDLE) && grant_found;

  // Next-state logic for the IDLE -> BUSY -> DONE -> IDLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)     state_next = ST_BUSY;
      ST_BUSY: if (cnt == '0)  state_next = ST_DONE;
      ST_DONE: if (rsp_ready)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: operand capture, settle counter, product capture and response flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            rsp_id <= grant_idx;
            rr_ptr <= rr_next;
            cnt    <= 4'(MUL_LAT - 1);
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_share_arbiter.sv
// Directed bench for approx_mult_share_arbiter with an exact-multiply stub.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on
// the rising edge.
module tb_approx_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           mul_a;
  logic [7:0]           mul_b;
  logic [15:0]          mul_p;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [15:0]          rsp_p;
  logic [ID_W-1:0]      rsp_id;
  logic [1:0]           state_dbg;

  logic [7:0] op_a [NUM_REQ];
  logic [7:0] op_b [NUM_REQ];

  int vectors;
  int miscompares;

  // Exact multiplier standing in for the shared approximate one.
  assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};
  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  approx_mult_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .state_dbg (state_dbg)
  );

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0]     rr_prod [5];
  logic [ID_W-1:0] rr_id   [5];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rsp_ready   = 1'b1;
    req_valid   = 4'b1111;
    op_a[0] = 8'd1;   op_b[0] = 8'd2;
    op_a[1] = 8'd13;  op_b[1] = 8'd11;
    op_a[2] = 8'd10;  op_b[2] = 8'd20;
    op_a[3] = 8'd255; op_b[3] = 8'd255;

    // 1: reset held two cycles with every request valid
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    chk("rst_rsp_p", 32'(rsp_p), 32'h0);
    rst_n = 1'b1;
    settle();
    chk("rst_first_grant", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;
    settle();
    chk("rst_no_req", 32'(req_ready), 32'h0);

    // 2: single op from req1, 13*11
    tick();
    req_valid = 4'b0010;
    settle();
    chk("single_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    settle();
    chk("single_busy_ready", 32'(req_ready), 32'h0);
    chk("single_mul_a", 32'(mul_a), 32'd13);
    chk("single_mul_b", 32'(mul_b), 32'd11);
    tick();
    chk("single_not_yet", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_p", 32'(rsp_p), 32'd143);
    chk("single_rsp_id", 32'(rsp_id), 32'd1);
    tick();
    chk("single_rsp_drop", 32'(rsp_valid), 32'h0);
    chk("single_idle_ready", 32'(req_ready), 32'h0);

    // 3: round robin from a fresh pointer, all four valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    rr_id[0] = 2'd0; rr_prod[0] = 16'd2;
    rr_id[1] = 2'd1; rr_prod[1] = 16'd143;
    rr_id[2] = 2'd2; rr_prod[2] = 16'd200;
    rr_id[3] = 2'd3; rr_prod[3] = 16'hFE01;
    rr_id[4] = 2'd0; rr_prod[4] = 16'd2;
    settle();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("rr_ready_%0d", n), 32'(req_ready), 32'(4'b0001 << rr_id[n]));
      tick();
      tick();
      tick();
      chk($sformatf("rr_valid_%0d", n), 32'(rsp_valid), 32'h1);
      chk($sformatf("rr_id_%0d", n), 32'(rsp_id), 32'(rr_id[n]));
      chk($sformatf("rr_p_%0d", n), 32'(rsp_p), 32'(rr_prod[n]));
      tick();
      settle();
    end
    chk("rr_next_grant", 32'(req_ready), 32'b0010);
    req_valid = 4'b0000;

    // 4: backpressure on req2 (10*20), pointer now at 1
    tick();
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    settle();
    chk("bp_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1001;
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("bp_valid_%0d", n), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_p_%0d", n), 32'(rsp_p), 32'd200);
      chk($sformatf("bp_id_%0d", n), 32'(rsp_id), 32'd2);
      chk($sformatf("bp_noready_%0d", n), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(req_ready), 32'h0);
    tick();
    chk("bp_rsp_drop", 32'(rsp_valid), 32'h0);
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    chk("bp_mul_a", 32'(mul_a), 32'd255);
    tick();
    tick();
    chk("bp_next_p", 32'(rsp_p), 32'hFE01);
    chk("bp_next_id", 32'(rsp_id), 32'd3);
    tick();

    // 5: reset during BUSY, pointer would otherwise be 2
    op_a[1] = 8'd0;
    op_b[1] = 8'd200;
    req_valid = 4'b0010;
    settle();
    chk("mid_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_abort_valid", 32'(rsp_valid), 32'h0);
    chk("mid_abort_mul_a", 32'(mul_a), 32'h0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("mid_quiet_%0d", n), 32'(rsp_valid), 32'h0);
    end
    req_valid = 4'b1010;
    settle();
    chk("mid_lowest_grant", 32'(req_ready), 32'b0010);

    // 6: req2 pulses during BUSY and withdraws; in-flight op is 0*200
    tick();
    req_valid = 4'b0100;
    settle();
    chk("wd_busy_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("wd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wd_rsp_p", 32'(rsp_p), 32'h0);
    chk("wd_rsp_id", 32'(rsp_id), 32'd1);
    tick();
    chk("wd_idle_ready", 32'(req_ready), 32'h0);
    req_valid = 4'b1111;
    settle();
    chk("wd_ptr_kept", 32'(req_ready), 32'b0100);
    req_valid = 4'b0000;
    tick();
    tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
